// File: rtl/reg_seq_pkg.sv
// Shared opcodes, access direction codes and state encoding for the register-transfer sequencer.
package reg_seq_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_LDI  = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH_IMM = 4'd1,
    ST_READ_RS   = 4'd2,
    ST_CAPT_A    = 4'd3,
    ST_READ_RD   = 4'd4,
    ST_CAPT_B    = 4'd5,
    ST_WRITE_RD  = 4'd6,
    ST_WRITE_RS  = 4'd7,
    ST_DONE      = 4'd8
  } state_e;

endpackage

// File: rtl/reg_transfer_sequencer.sv
// Expands NOP/LDI/MOV/SWAP instructions into fixed read/write cycles on a 4-entry register file.
// All outputs are decoded from the state register, so an async reset drops the access strobe at once.
import reg_seq_pkg::*;

module reg_transfer_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  input  logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  register_enable,
  output logic                  read_write,
  output logic [SEL_WIDTH-1:0]  register_select,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] reg_rdata
);

  localparam int OP_LSB = DATA_WIDTH - 2;
  localparam int RD_LSB = OP_LSB - SEL_WIDTH;
  localparam int RS_LSB = RD_LSB - SEL_WIDTH;

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [SEL_WIDTH-1:0]  rd_q, rd_d;
  logic [SEL_WIDTH-1:0]  rs_q, rs_d;
  logic [DATA_WIDTH-1:0] tmp_a_q, tmp_a_d;
  logic [DATA_WIDTH-1:0] tmp_b_q, tmp_b_d;
  logic                  accept;
  logic [1:0]            instr_op;
  logic                  unused_rsvd;

  assign accept      = instr_valid & instr_ready;
  assign instr_op    = instr[OP_LSB +: 2];
  assign unused_rsvd = ^instr[RS_LSB-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      rd_q    <= '0;
      rs_q    <= '0;
      tmp_a_q <= '0;
      tmp_b_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      tmp_a_q <= tmp_a_d;
      tmp_b_q <= tmp_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    tmp_a_d = tmp_a_q;
    tmp_b_d = tmp_b_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = instr_op;
          rd_d = instr[RD_LSB +: SEL_WIDTH];
          rs_d = instr[RS_LSB +: SEL_WIDTH];
          case (instr_op)
            OP_NOP:  state_d = ST_DONE;
            OP_LDI:  state_d = ST_FETCH_IMM;
            default: state_d = ST_READ_RS;
          endcase
        end
      end
      ST_FETCH_IMM: begin
        if (accept) begin
          tmp_a_d = instr;
          state_d = ST_WRITE_RD;
        end
      end
      ST_READ_RS: state_d = ST_CAPT_A;
      // Read data is only valid the cycle after the strobe, hence the capture states.
      ST_CAPT_A: begin
        tmp_a_d = reg_rdata;
        state_d = (op_q == OP_SWAP) ? ST_READ_RD : ST_WRITE_RD;
      end
      ST_READ_RD: state_d = ST_CAPT_B;
      ST_CAPT_B: begin
        tmp_b_d = reg_rdata;
        state_d = ST_WRITE_RD;
      end
      ST_WRITE_RD: state_d = (op_q == OP_SWAP) ? ST_WRITE_RS : ST_DONE;
      ST_WRITE_RS: state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready     = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    register_enable = 1'b0;
    read_write      = RW_READ;
    register_select = '0;
    reg_wdata       = '0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      ST_FETCH_IMM: instr_ready = 1'b1;
      ST_READ_RS: begin
        register_enable = 1'b1;
        register_select = rs_q;
      end
      ST_READ_RD: begin
        register_enable = 1'b1;
        register_select = rd_q;
      end
      ST_WRITE_RD: begin
        register_enable = 1'b1;
        read_write      = RW_WRITE;
        register_select = rd_q;
        reg_wdata       = tmp_a_q;
      end
      ST_WRITE_RS: begin
        register_enable = 1'b1;
        read_write      = RW_WRITE;
        register_select = rs_q;
        reg_wdata       = tmp_b_q;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Directed bench: sequencer driving a behavioural 4x8 register file, per-cycle bus checks.
module tb_reg_transfer_sequencer;

  logic       clk;
  logic       reset;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic       busy;
  logic       done;
  logic       register_enable;
  logic       read_write;
  logic [1:0] register_select;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;

  logic [7:0] rf [4];
  logic [14:0] obs;

  int errors = 0;
  int checks = 0;

  // {busy, instr_ready, done, en, rw, sel, wdata}
  localparam logic [14:0] V_IDLE  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00};
  localparam logic [14:0] V_FETCH = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00};
  localparam logic [14:0] V_CAPT  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00};
  localparam logic [14:0] V_DONE  = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 8'h00};

  reg_transfer_sequencer #(.DATA_WIDTH(8), .SEL_WIDTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_ready     (instr_ready),
    .busy            (busy),
    .done            (done),
    .register_enable (register_enable),
    .read_write      (read_write),
    .register_select (register_select),
    .reg_wdata       (reg_wdata),
    .reg_rdata       (reg_rdata)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) begin
    if (register_enable) begin
      if (read_write) reg_rdata <= rf[register_select];
      else            rf[register_select] <= reg_wdata;
    end
  end

  assign obs = {busy, instr_ready, done, register_enable, read_write, register_select, reg_wdata};

  function automatic logic [14:0] rd_v(input logic [1:0] s);
    return {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, s, 8'h00};
  endfunction

  function automatic logic [14:0] wr_v(input logic [1:0] s, input logic [7:0] d);
    return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, s, d};
  endfunction

  // Loads a register through the DUT; entered and left at a negedge with the DUT idle.
  task automatic ldi(input logic [1:0] r, input logic [7:0] v);
    instr_valid = 1'b1;
    instr = {2'b10, r, 4'b0000};
    @(negedge clk);
    instr = v;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = 8'h00;
    #5;
    checks++;
    if (obs !== V_IDLE) begin
      errors++;
      $display("FAIL reset_asserted: got %h expected %h", obs, V_IDLE);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== V_IDLE) begin
      errors++;
      $display("FAIL reset_released: got %h expected %h", obs, V_IDLE);
    end
  endtask

  task automatic test_ldi();
    logic [14:0] exp_v [4];
    exp_v = '{V_FETCH, wr_v(2'd2, 8'h0F), V_DONE, V_IDLE};
    instr_valid = 1'b1;
    instr = 8'b10_10_00_00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL ldi cycle %0d: got %h expected %h", i + 1, obs, exp_v[i]);
      end
      if (i == 0) instr = 8'h0F;
      else        instr_valid = 1'b0;
    end
    checks++;
    if (rf[2] !== 8'h0F) begin
      errors++;
      $display("FAIL ldi_r2: got %h expected 0f", rf[2]);
    end
  endtask

  task automatic test_nop();
    logic [14:0] exp_v [2];
    exp_v = '{V_DONE, V_IDLE};
    instr_valid = 1'b1;
    instr = 8'h03;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL nop cycle %0d: got %h expected %h", i + 1, obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_mov();
    logic [14:0] exp_v [5];
    ldi(2'd1, 8'hA5);
    exp_v = '{rd_v(2'd1), V_CAPT, wr_v(2'd3, 8'hA5), V_DONE, V_IDLE};
    instr_valid = 1'b1;
    instr = 8'b01_11_01_00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL mov cycle %0d: got %h expected %h", i + 1, obs, exp_v[i]);
      end
    end
    checks++;
    if (rf[3] !== 8'hA5 || rf[1] !== 8'hA5) begin
      errors++;
      $display("FAIL mov_regs: got r1=%h r3=%h expected r1=a5 r3=a5", rf[1], rf[3]);
    end
  endtask

  task automatic test_swap();
    logic [14:0] exp_v [8];
    ldi(2'd0, 8'h11);
    ldi(2'd3, 8'h22);
    exp_v = '{rd_v(2'd3), V_CAPT, rd_v(2'd0), V_CAPT,
              wr_v(2'd0, 8'h22), wr_v(2'd3, 8'h11), V_DONE, V_IDLE};
    instr_valid = 1'b1;
    instr = 8'b11_00_11_00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL swap cycle %0d: got %h expected %h", i + 1, obs, exp_v[i]);
      end
    end
    checks++;
    if (rf[0] !== 8'h22 || rf[3] !== 8'h11) begin
      errors++;
      $display("FAIL swap_regs: got r0=%h r3=%h expected r0=22 r3=11", rf[0], rf[3]);
    end

    ldi(2'd2, 8'h5A);
    exp_v = '{rd_v(2'd2), V_CAPT, rd_v(2'd2), V_CAPT,
              wr_v(2'd2, 8'h5A), wr_v(2'd2, 8'h5A), V_DONE, V_IDLE};
    instr_valid = 1'b1;
    instr = 8'b11_10_10_00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL swap_self cycle %0d: got %h expected %h", i + 1, obs, exp_v[i]);
      end
    end
    checks++;
    if (rf[2] !== 8'h5A) begin
      errors++;
      $display("FAIL swap_self_reg: got r2=%h expected 5a", rf[2]);
    end
  endtask

  task automatic test_hold_valid();
    logic [14:0] exp_v [6];
    exp_v = '{rd_v(2'd2), V_CAPT, wr_v(2'd0, 8'h5A), V_DONE, V_IDLE, V_IDLE};
    instr_valid = 1'b1;
    instr = 8'b01_00_10_11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL hold_valid cycle %0d: got %h expected %h", i + 1, obs, exp_v[i]);
      end
      if (i == 0) instr = 8'b01_01_10_00;
      if (i == 3) instr_valid = 1'b0;
    end
    checks++;
    if (rf[0] !== 8'h5A || rf[1] !== 8'hA5) begin
      errors++;
      $display("FAIL hold_valid_regs: got r0=%h r1=%h expected r0=5a r1=a5", rf[0], rf[1]);
    end
  endtask

  task automatic test_reset_abort();
    logic [14:0] exp_v [4];
    ldi(2'd1, 8'h77);
    ldi(2'd3, 8'h88);
    exp_v = '{rd_v(2'd3), V_CAPT, rd_v(2'd1), V_CAPT};
    instr_valid = 1'b1;
    instr = 8'b11_01_11_00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL abort_swap cycle %0d: got %h expected %h", i + 1, obs, exp_v[i]);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== V_IDLE) begin
      errors++;
      $display("FAIL abort_swap_reset: got %h expected %h", obs, V_IDLE);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== V_IDLE || rf[1] !== 8'h77 || rf[3] !== 8'h88) begin
      errors++;
      $display("FAIL abort_swap_regs: got bus=%h r1=%h r3=%h expected bus=%h r1=77 r3=88",
               obs, rf[1], rf[3], V_IDLE);
    end

    exp_v = '{rd_v(2'd1), V_CAPT, wr_v(2'd2, 8'h77), V_IDLE};
    instr_valid = 1'b1;
    instr = 8'b01_10_01_00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL abort_mov cycle %0d: got %h expected %h", i + 1, obs, exp_v[i]);
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (register_enable !== 1'b0 || obs !== V_IDLE) begin
      errors++;
      $display("FAIL abort_mov_en_drop: got %h expected %h", obs, V_IDLE);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rf[2] !== 8'h5A) begin
      errors++;
      $display("FAIL abort_mov_reg: got r2=%h expected 5a", rf[2]);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_nop();
    test_mov();
    test_swap();
    test_hold_valid();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
